// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/prefetch front end.
package fetch_pkg;

    // Width of the fields stored in a queue entry; the top casts into these.
    localparam int unsigned FETCH_XLEN = 32;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with clear; head is read combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  fetch_entry_t             i_entry,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Storage write; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear && i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointer and occupancy update; clear wins over push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // The credit scheme upstream must never let a push land on a full queue.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
        !(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));

    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
        !(i_pop && (r_count == '0)));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC generation, credit-limited in-order instruction requests,
// response queueing and redirect squashing.
// Optional: define FETCH_PERF_CNT_EN to add saturating performance counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic                     stall_d,
    output logic                     imem_req_valid,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_empty_cycles,
    output logic [31:0]              perf_squashed,
`endif
    output logic                     valid_f,
    output logic [DATA_WIDTH-1:0]    instr_f,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(PC_STEP);

    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
    logic [ADDRESS_WIDTH-1:0] r_rsp_pc;
    logic [CNT_W-1:0]         r_outstanding;  // live requests awaiting a response
    logic [CNT_W-1:0]         r_discard;      // squashed requests still to return
    logic [ADDRESS_WIDTH-1:0] r_hold_pc;
    logic [ADDRESS_WIDTH-1:0] r_hold_pc4;
    logic [DATA_WIDTH-1:0]    r_hold_instr;

    logic [CNT_W-1:0]         w_count;
    logic                     w_empty;
    logic                     w_valid;
    logic [SUM_W-1:0]         w_in_use;
    logic                     w_req_fire;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_rsp_drop;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic [ADDRESS_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0]    w_head_instr;
    fetch_entry_t             w_push_entry;
    fetch_entry_t             w_head;

    // Credits cover both queued entries and live in-flight requests.
    assign w_in_use       = SUM_W'(w_count) + SUM_W'(r_outstanding);
    assign imem_req_valid = !rst && !pc_src_e && (w_in_use < SUM_W'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_target   = pc_target_e & ~ADDRESS_WIDTH'(3);
    assign w_rsp_drop = imem_rsp_valid && (pc_src_e || (r_discard != '0));
    assign w_push     = imem_rsp_valid && !pc_src_e && (r_discard == '0);
    assign w_valid    = !w_empty;
    // Decode is flushed alongside a redirect, so its pop is ignored then.
    assign w_pop      = w_valid && !stall_d && !pc_src_e;

    assign w_push_entry.pc    = FETCH_XLEN'(r_rsp_pc);
    assign w_push_entry.instr = FETCH_XLEN'(imem_rsp_data);
    assign w_head_pc          = ADDRESS_WIDTH'(w_head.pc);
    assign w_head_instr       = DATA_WIDTH'(w_head.instr);

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (pc_src_e),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // PC, credit and squash bookkeeping; a redirect moves live requests to discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (pc_src_e) begin
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_outstanding <= '0;
            r_discard     <= r_discard + r_outstanding - CNT_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
            if (w_push)     r_rsp_pc   <= r_rsp_pc + STEP;
            if (imem_rsp_valid && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_push);
        end
    end

    // Remember the last presented head so outputs hold while the queue is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_pc    <= '0;
            r_hold_pc4   <= '0;
            r_hold_instr <= '0;
        end else if (w_valid) begin
            r_hold_pc    <= w_head_pc;
            r_hold_pc4   <= w_head_pc + STEP;
            r_hold_instr <= w_head_instr;
        end
    end

    assign valid_f    = w_valid;
    assign pc_f       = w_valid ? w_head_pc : r_hold_pc;
    assign pc_plus4_f = w_valid ? (w_head_pc + STEP) : r_hold_pc4;
    assign instr_f    = w_valid ? w_head_instr : r_hold_instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_empty;
    logic [31:0] r_perf_squash;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall  <= '0;
            r_perf_empty  <= '0;
            r_perf_squash <= '0;
        end else begin
            if (w_valid && stall_d && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
            if (!w_valid && (r_perf_empty != '1))           r_perf_empty <= r_perf_empty + 32'd1;
            if (w_rsp_drop && (r_perf_squash != '1))        r_perf_squash <= r_perf_squash + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_empty_cycles = r_perf_empty;
    assign perf_squashed     = r_perf_squash;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based reference model.
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_empty_cycles;
    logic [31:0] perf_squashed;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .DEPTH         (DEPTH),
        .RESET_PC      (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src_e       (pc_src_e),
        .pc_target_e    (pc_target_e),
        .stall_d        (stall_d),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_empty_cycles (perf_empty_cycles),
        .perf_squashed     (perf_squashed),
`endif
        .valid_f        (valid_f),
        .instr_f        (instr_f),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          due;
    } mem_req_t;

    // Memory model: in-order pending requests tagged with the redirect epoch.
    mem_req_t    mem_q[$];
    // Fetch model: PCs delivered to decode since the last redirect, oldest first.
    logic [31:0] pq[$];
    int          live;        // requests issued since redirect and not yet popped
    logic [31:0] next_req;
    int unsigned epoch;
    int          last_due;
    logic [31:0] last_pc, last_pc4, last_instr;
    int unsigned m_stall, m_empty, m_squash;
    bit          model_ok;

    int          cyc;
    int          n_cmp, n_err;

    // Stimulus knobs.
    bit          k_rst;
    int          k_ready_pct, k_stall_pct, k_redir_pct, k_lat_min, k_lat_max;
    bit          k_tgt_fixed;
    logic [31:0] k_tgt;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32'h0019_660D + 32'h3C6E_F35F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_model();
        mem_q.delete();
        pq.delete();
        live       = 0;
        next_req   = RST_PC;
        epoch      = epoch + 1;
        last_due   = 0;
        last_pc    = '0;
        last_pc4   = '0;
        last_instr = '0;
        m_stall    = 0;
        m_empty    = 0;
        m_squash   = 0;
        model_ok   = 1'b1;
    endtask

    task automatic step();
        mem_req_t    m;
        bit          rsp_now, exp_valid, exp_req;
        logic [31:0] head;
        int          d;

        @(negedge clk);
        rst            = k_rst;
        pc_src_e       = !k_rst && ($urandom_range(99) < k_redir_pct);
        pc_target_e    = k_tgt_fixed ? k_tgt : 32'($urandom_range(4095));
        stall_d        = ($urandom_range(99) < k_stall_pct);
        imem_req_ready = ($urandom_range(99) < k_ready_pct);
        rsp_now        = !k_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_data(mem_q[0].addr) : $urandom;
        #1;

        exp_valid = (pq.size() > 0);
        head      = exp_valid ? pq[0] : 32'h0;
        exp_req   = !rst && !pc_src_e && (live < DEPTH);

        if (model_ok) begin
            check_eq("valid_f", {31'b0, valid_f}, {31'b0, exp_valid});
            check_eq("pc_f", pc_f, exp_valid ? head : last_pc);
            check_eq("pc_plus4_f", pc_plus4_f, exp_valid ? head + 32'd4 : last_pc4);
            check_eq("instr_f", instr_f, exp_valid ? mem_data(head) : last_instr);
            check_eq("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (exp_req) check_eq("imem_req_addr", imem_req_addr, next_req);
`ifdef FETCH_PERF_CNT_EN
            check_eq("perf_stall", perf_stall_cycles, m_stall);
            check_eq("perf_empty", perf_empty_cycles, m_empty);
            check_eq("perf_squash", perf_squashed, m_squash);
`endif
        end

        if (rst) begin
            reset_model();
        end else begin
            if (exp_valid && stall_d) m_stall++;
            if (!exp_valid) m_empty++;
            if (exp_valid) begin
                last_pc    = head;
                last_pc4   = head + 32'd4;
                last_instr = mem_data(head);
            end
            if (exp_valid && !stall_d && !pc_src_e) begin
                void'(pq.pop_front());
                live--;
            end
            if (rsp_now) begin
                m = mem_q.pop_front();
                if (pc_src_e || (m.epoch != epoch)) m_squash++;
                else pq.push_back(m.addr);
            end
            if (exp_req && imem_req_ready) begin
                d = cyc + $urandom_range(k_lat_max, k_lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{addr: next_req, epoch: epoch, due: d});
                next_req = next_req + 32'd4;
                live++;
            end
            if (pc_src_e) begin
                pq.delete();
                live     = 0;
                next_req = pc_target_e & ~32'd3;
                epoch    = epoch + 1;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; epoch = 0; model_ok = 1'b0;
        rst = 1'b1; pc_src_e = 1'b0; pc_target_e = '0; stall_d = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        k_tgt_fixed = 1'b0; k_tgt = 32'h200;
        k_ready_pct = 100; k_stall_pct = 0; k_redir_pct = 0; k_lat_min = 1; k_lat_max = 1;

        // Reset, then zero-latency streaming.
        k_rst = 1'b1; run(3);
        k_rst = 1'b0; run(20);

        // Decode stall fills the credit window, then release.
        k_stall_pct = 100; run(10);
        k_stall_pct = 0;   run(20);

        // Three-cycle memory with a redirect to 0x200.
        k_lat_min = 3; k_lat_max = 3; run(6);
        k_tgt_fixed = 1'b1; k_redir_pct = 100; run(1);
        k_redir_pct = 0; run(15);
        k_tgt_fixed = 1'b0;

        // Memory refuses requests for a while.
        k_ready_pct = 0; run(5);
        k_ready_pct = 100; run(10);

        // Reset while the queue is full.
        k_lat_min = 1; k_lat_max = 1;
        k_stall_pct = 100; run(8);
        k_rst = 1'b1; run(1);
        k_rst = 1'b0; k_stall_pct = 0; run(10);

        // Randomized mixes.
        for (int blk = 0; blk < 60; blk++) begin
            k_ready_pct = $urandom_range(100, 30);
            k_stall_pct = $urandom_range(60, 0);
            k_redir_pct = $urandom_range(12, 0);
            k_lat_min   = $urandom_range(2, 1);
            k_lat_max   = $urandom_range(4, k_lat_min);
            k_rst       = ($urandom_range(19) == 0);
            run(1);
            k_rst = 1'b0;
            run(49);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Front-end fetch block sitting directly upstream of the fetch/decode pipeline register.
- Generates the PC and issues in-order requests to an instruction memory with a valid/ready handshake.
- Buffers returned instructions in a small queue and presents {pc, pc+4, instr} with a valid flag to decode.
- On an execute-stage redirect it flushes the queue and squashes in-flight responses, then restarts fetch at the target.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDRESS_WIDTH, 32, PC width.
- DEPTH, 4, queue entries; also the cap on queued plus in-flight requests; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc_src_e  in  1  redirect request from execute.
- pc_target_e  in  ADDRESS_WIDTH  redirect target.
- stall_d  in  1  decode cannot accept this cycle.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  ADDRESS_WIDTH  request address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response valid; responses return in order; no backpressure.
- imem_rsp_data  in  DATA_WIDTH  response instruction.
- valid_f  out  1  head entry valid.
- instr_f  out  DATA_WIDTH  head instruction.
- pc_f  out  ADDRESS_WIDTH  head PC.
- pc_plus4_f  out  ADDRESS_WIDTH  head PC + 4.

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; discard = 0.
  - Outputs: valid_f = 0, imem_req_valid = 0, instr_f = 0, pc_f = 0, pc_plus4_f = 0.
  - Reset mid-operation drops everything. Responses arriving after reset for pre-reset requests are a memory-side protocol violation; memory is reset on the same rst.
- Request issue:
  - imem_req_valid = !rst && !pc_src_e && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 (wraps modulo 2^ADDRESS_WIDTH) and outstanding increments.
- Response handling:
  - When discard > 0: discard decrements and the data is dropped.
  - Otherwise: push {pc, instr} into the queue. The PC is tracked by rsp_pc, which advances by 4 per accepted response.
  - The credit rule guarantees a push never finds the queue full. Overflow is an assertion failure.
- Dequeue:
  - Head is presented combinationally from the queue.
  - The head pops when valid_f && !stall_d.
  - Push and pop in the same cycle keep count unchanged.
  - Empty queue gives valid_f = 0; instr_f, pc_f and pc_plus4_f hold their last values.
- Bypass: none. Latency from request handshake to the earliest valid_f is memory latency + 1 cycle (registered queue write).
- Redirect (pc_src_e = 1), in that cycle:
  - No request is issued.
  - Queue clears and valid_f = 0 on the next cycle.
  - fetch_pc and rsp_pc are set to pc_target_e.
  - discard = discard + outstanding − (1 if a response arrives this cycle).
  - The response arriving that cycle is dropped.
  - A pop in the same cycle is ignored: decode is being flushed too.
  - The first request at the target is issued the next cycle.
- Back-to-back redirects: each accumulates discard as above; the last target wins.
- Counters: outstanding and discard are clog2(DEPTH)+1 bits wide.
- Misaligned targets (low 2 bits ≠ 0): forced to a word boundary by zeroing bits [1:0].

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit read-only output ports:
  - perf_stall_cycles: counts cycles with valid_f && stall_d.
  - perf_empty_cycles: counts cycles with !valid_f && !rst.
  - perf_squashed: counts dropped responses.
- All three counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - INSTR_NOP = 32'h0000_0013
  - PC_STEP = 4
  - default RESET_PC
  - typedef fetch_entry_t {pc, instr}
- One sub-module, fetch_queue: synchronous FIFO of fetch_entry_t with DEPTH entries, push/pop/clear, count output, and head read.
- Issue/credit/discard logic stays in the top.

Test Plan:
- Zero-latency memory (rsp one cycle after req), stall_d = 0, RESET_PC = 0x100:
  - valid_f first asserted 2 cycles after rst deasserts with pc_f = 0x100, pc_plus4_f = 0x104.
  - pc_f then increments by 4 every cycle.
- stall_d held 1 for 10 cycles:
  - count + outstanding never exceeds 4; exactly 4 requests accepted; valid_f stays 1 with pc_f frozen.
  - On release, pc_f sequence is contiguous with no gaps or duplicates.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x200:
  - The next 3 responses are dropped; the first valid_f after the redirect shows pc_f = 0x200 with the data returned for 0x200.
- Redirect coinciding with a response and an attempted pop:
  - The response is dropped, discard is computed correctly, imem_req_valid = 0 that cycle, and the next request address is 0x200.
- imem_req_ready held 0 for 5 cycles:
  - imem_req_addr is stable, fetch_pc does not advance, and valid_f goes 0 once the queue drains.
- Reset asserted mid-stream with a full queue:
  - The next cycle shows valid_f = 0 and imem_req_valid = 0.
  - After release, the first request address is RESET_PC.
  - With FETCH_PERF_CNT_EN defined, all counters read 0.
